// File: rtl/doom_pkg.sv
// Shared raycaster constants and types.
// Provides screen geometry, bus widths, default ceiling/floor colours and
// the column renderer state encoding.
package doom_pkg;

   localparam int unsigned SCREEN_HEIGHT = 120;
   localparam int unsigned SCREEN_WIDTH  = 160;

   localparam int unsigned COLOUR_W = 18;
   localparam int unsigned X_W      = 8;
   localparam int unsigned Y_W      = 7;

   localparam logic [COLOUR_W-1:0] CEILING_COLOUR = 18'h0_0FC0;
   localparam logic [COLOUR_W-1:0] FLOOR_COLOUR   = 18'h0_3000;

   typedef enum logic [3:0] {
      IDLE,
      CALC,
      CEIL_REQ,
      CEIL_WAIT,
      WALL_REQ,
      WALL_WAIT,
      FLOOR_REQ,
      FLOOR_WAIT,
      DONE
   } column_state_t;

endpackage

// File: rtl/draw_column_if.sv
// Request bus between the column renderer and the vertical-line drawer.
//   line_start  : one-cycle request pulse (renderer -> drawer)
//   line_done   : one-cycle completion pulse (drawer -> renderer)
//   line_x      : column to draw
//   line_min_y  : first row, inclusive
//   line_max_y  : last row, inclusive
//   line_colour : segment colour
// master = renderer side, slave = drawer side.
interface draw_column_if;
   import doom_pkg::*;

   logic                line_start;
   logic                line_done;
   logic [X_W-1:0]      line_x;
   logic [Y_W-1:0]      line_min_y;
   logic [Y_W-1:0]      line_max_y;
   logic [COLOUR_W-1:0] line_colour;

   modport master (
      output line_start, line_x, line_min_y, line_max_y, line_colour,
      input  line_done
   );

   modport slave (
      input  line_start, line_x, line_min_y, line_max_y, line_colour,
      output line_done
   );

endinterface

// File: rtl/column_bounds.sv
// Combinational column geometry.
// Clamps the projected wall height to the screen and centres the wall slice.
//   wall_height : projected wall height in pixels
//   h           : clamped wall height
//   top         : first wall row
//   floor_y     : first floor row (top + h, at most SCREEN_HEIGHT)
//   ceil_valid  : ceiling segment non-empty
//   wall_valid  : wall segment non-empty
//   floor_valid : floor segment non-empty
module column_bounds #(
   parameter int unsigned SCREEN_HEIGHT = doom_pkg::SCREEN_HEIGHT
) (
   input  logic [doom_pkg::Y_W-1:0] wall_height,
   output logic [doom_pkg::Y_W-1:0] h,
   output logic [doom_pkg::Y_W-1:0] top,
   output logic [doom_pkg::Y_W-1:0] floor_y,
   output logic                     ceil_valid,
   output logic                     wall_valid,
   output logic                     floor_valid
);
   import doom_pkg::*;

   localparam logic [Y_W-1:0] ROWS = Y_W'(SCREEN_HEIGHT);

   always_comb begin
      h           = (wall_height > ROWS) ? ROWS : wall_height;
      top         = (ROWS - h) >> 1;
      floor_y     = top + h;
      ceil_valid  = (top != '0);
      wall_valid  = (h != '0);
      floor_valid = (floor_y < ROWS);
   end

endmodule

// File: rtl/draw_column.sv
// Renders one screen column as up to three vertical-line requests
// (ceiling, wall, floor) issued in order to the downstream line drawer.
//   clock, reset : system clock, synchronous active-high reset
//   start        : one-cycle request, accepted only when idle
//   x            : column index, latched on accepted start
//   wall_height  : projected wall height, latched on accepted start
//   wall_colour  : wall colour, latched on accepted start
//   busy         : high whenever not idle
//   done         : one-cycle pulse when the column is finished
//   line         : request bus to the line drawer (master side)
module draw_column #(
   parameter int unsigned                     SCREEN_HEIGHT  = doom_pkg::SCREEN_HEIGHT,
   parameter logic [doom_pkg::COLOUR_W-1:0]   CEILING_COLOUR = doom_pkg::CEILING_COLOUR,
   parameter logic [doom_pkg::COLOUR_W-1:0]   FLOOR_COLOUR   = doom_pkg::FLOOR_COLOUR
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
   input  logic [doom_pkg::X_W-1:0]      x,
   input  logic [doom_pkg::Y_W-1:0]      wall_height,
   input  logic [doom_pkg::COLOUR_W-1:0] wall_colour,
   output logic                          busy,
   output logic                          done,
   draw_column_if.master                 line
);
   import doom_pkg::*;

   localparam logic [Y_W-1:0] LAST_ROW = Y_W'(SCREEN_HEIGHT - 1);

   column_state_t state, next_state;

   logic [X_W-1:0]      x_q;
   logic [Y_W-1:0]      wall_height_q;
   logic [COLOUR_W-1:0] colour_q;

   logic [Y_W-1:0] h_q, top_q, floor_q;
   logic           ceil_valid_q, wall_valid_q, floor_valid_q;

   logic [Y_W-1:0] b_h, b_top, b_floor;
   logic           b_ceil_valid, b_wall_valid, b_floor_valid;

   column_bounds #(
      .SCREEN_HEIGHT (SCREEN_HEIGHT)
   ) u_bounds (
      .wall_height (wall_height_q),
      .h           (b_h),
      .top         (b_top),
      .floor_y     (b_floor),
      .ceil_valid  (b_ceil_valid),
      .wall_valid  (b_wall_valid),
      .floor_valid (b_floor_valid)
   );

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:       if (start) next_state = CALC;
         CALC:       next_state = CEIL_REQ;
         CEIL_REQ:   next_state = ceil_valid_q  ? CEIL_WAIT  : WALL_REQ;
         CEIL_WAIT:  if (line.line_done) next_state = WALL_REQ;
         WALL_REQ:   next_state = wall_valid_q  ? WALL_WAIT  : FLOOR_REQ;
         WALL_WAIT:  if (line.line_done) next_state = FLOOR_REQ;
         FLOOR_REQ:  next_state = floor_valid_q ? FLOOR_WAIT : DONE;
         FLOOR_WAIT: if (line.line_done) next_state = DONE;
         DONE:       next_state = IDLE;
         default:    next_state = IDLE;
      endcase
   end

   always_comb begin
      busy            = (state != IDLE);
      done            = (state == DONE);
      line.line_start = ((state == CEIL_REQ)  && ceil_valid_q) ||
                        ((state == WALL_REQ)  && wall_valid_q) ||
                        ((state == FLOOR_REQ) && floor_valid_q);
   end

   // Segment bounds are loaded on the edge that enters a *_REQ state so they
   // are already valid alongside the line_start pulse. Entering CEIL_REQ
   // happens on the same edge that registers the geometry, so the ceiling
   // uses the combinational bounds; later segments use the registered copy.
   always_ff @(posedge clock) begin
      if (reset) begin
         x_q              <= '0;
         wall_height_q    <= '0;
         colour_q         <= '0;
         h_q              <= '0;
         top_q            <= '0;
         floor_q          <= '0;
         ceil_valid_q     <= 1'b0;
         wall_valid_q     <= 1'b0;
         floor_valid_q    <= 1'b0;
         line.line_x      <= '0;
         line.line_min_y  <= '0;
         line.line_max_y  <= '0;
         line.line_colour <= '0;
      end else begin
         if ((state == IDLE) && start) begin
            x_q           <= x;
            wall_height_q <= wall_height;
            colour_q      <= wall_colour;
         end

         if (state == CALC) begin
            h_q           <= b_h;
            top_q         <= b_top;
            floor_q       <= b_floor;
            ceil_valid_q  <= b_ceil_valid;
            wall_valid_q  <= b_wall_valid;
            floor_valid_q <= b_floor_valid;
         end

         case (next_state)
            CEIL_REQ: if (b_ceil_valid) begin
               line.line_x      <= x_q;
               line.line_min_y  <= '0;
               line.line_max_y  <= b_top - Y_W'(1);
               line.line_colour <= CEILING_COLOUR;
            end
            WALL_REQ: if (wall_valid_q) begin
               line.line_x      <= x_q;
               line.line_min_y  <= top_q;
               line.line_max_y  <= top_q + h_q - Y_W'(1);
               line.line_colour <= colour_q;
            end
            FLOOR_REQ: if (floor_valid_q) begin
               line.line_x      <= x_q;
               line.line_min_y  <= floor_q;
               line.line_max_y  <= LAST_ROW;
               line.line_colour <= FLOOR_COLOUR;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/draw_column.md
# draw_column

Renders one complete screen column (ceiling, wall slice, floor) for the raycaster. It takes a column index and a projected wall height, then drives up to three sequential requests through a start/done handshake to the vertical-line drawer directly downstream, which performs the VGA pixel writes. It sits between the per-column ray/distance stage and the line drawer, and processes one column per `start`.

## Interface
- `SCREEN_HEIGHT`, 120: visible rows; y range 0..119.
- `CEILING_COLOUR`, 18'h0_0FC0: ceiling colour.
- `FLOOR_COLOUR`, 18'h0_3000: floor colour.
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `x` in 8: column index, latched on accepted start.
- `wall_height` in 7: projected wall height in pixels, latched on accepted start.
- `wall_colour` in 18: wall colour, latched on accepted start.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the column is finished.
- `line_start` out 1: one-cycle pulse to the line drawer.
- `line_done` in 1: one-cycle completion pulse from the line drawer.
- `line_x` out 8: column for the drawer.
- `line_min_y` out 7: first row, inclusive.
- `line_max_y` out 7: last row, inclusive.
- `line_colour` out 18: segment colour.

## Operation
- Width rules:
  - `h = min(wall_height, SCREEN_HEIGHT)`.
  - `top = (SCREEN_HEIGHT - h) >> 1`, using a floor shift.
  - `floor_y = top + h`, which is always ≤ 120 and fits in 7 bits.
  - The wall spans `top..floor_y-1`.
- Segments, issued in this fixed order:
  - Ceiling `0..top-1`, issued only if `top > 0`.
  - Wall `top..floor_y-1`, issued only if `h > 0`.
  - Floor `floor_y..SCREEN_HEIGHT-1`, issued only if `floor_y < SCREEN_HEIGHT`.
- Empty segments are skipped entirely, with no `line_start` issued. The drawer always writes at least one pixel, so an empty segment must never reach it.
- States:
  - IDLE → CALC when `start` is high. Latch `x`, `wall_height` and `wall_colour`.
  - CALC: register `h`, `top` and `floor_y`, then go to CEIL_REQ.
  - CEIL_REQ: if the segment is non-empty, drive its bounds and pulse `line_start`, then go to CEIL_WAIT. Otherwise go to WALL_REQ.
  - CEIL_WAIT: go to WALL_REQ on `line_done`.
  - WALL_REQ / WALL_WAIT: same pattern as ceiling. WALL_WAIT goes to FLOOR_REQ.
  - FLOOR_REQ / FLOOR_WAIT: same pattern. Both exit to DONE.
  - DONE: pulse `done`, then go to IDLE.
- `start` is ignored outside IDLE; it is not queued.
- `line_x`, `line_min_y`, `line_max_y` and `line_colour` are registered. They are written in the *_REQ cycle and held constant through the matching *_WAIT, because the drawer samples them over several cycles.
- `line_done` arriving outside a *_WAIT state is ignored.
- Reset values:
  - State is IDLE.
  - `busy`, `done` and `line_start` are 0.
  - `line_x`, `line_min_y`, `line_max_y` and `line_colour` are 0.
- Reset mid-operation: return to IDLE on the next edge with no `done` pulse. The downstream drawer shares the same reset.

## Timing
- From `start` to the first `line_start`: 3 cycles (IDLE, CALC, CEIL_REQ), with the pulse in the CEIL_REQ cycle.
- A skipped segment costs 1 cycle in its REQ state.
- An issued segment costs 1 cycle plus the time until `line_done` arrives.
- `done` is asserted the cycle after the last segment completes or is skipped.
- The earliest `start` after `done` is the cycle following `done`, i.e. back in IDLE.
- `line_start` and `done` are each high for exactly one cycle per event.

## Structure
- Shared package `doom_pkg`:
  - `SCREEN_HEIGHT` and `SCREEN_WIDTH`.
  - `COLOUR_W = 18`, `X_W = 8`, `Y_W = 7`.
  - Default ceiling and floor colour constants.
- One combinational sub-module, `column_bounds`: maps `wall_height` to `h`, `top`, `floor_y` and the three segment-valid flags. The FSM and output registers stay in `draw_column`.

## Test plan
- `wall_height=40`, x=10 → exactly three `line_start` pulses, all with `line_x=10`:
  - (0,39,CEILING_COLOUR)
  - (40,79,wall_colour)
  - (80,119,FLOOR_COLOUR)
  - followed by a single `done`.
- `wall_height=0` → two requests, (0,59) ceiling and (60,119) floor; no wall request.
- `wall_height=127` (clamped) and `wall_height=120` → each gives exactly one request, (0,119) wall; no ceiling or floor.
- `wall_height=1` → three requests: (0,58) ceiling, (59,59) wall, (60,119) floor.
- `wall_height=119` → no ceiling; two requests: (0,118) wall, (119,119) floor.
- Protocol checks:
  - Delay `line_done` by 0 cycles, then by 50 cycles → bounds stay stable throughout each wait.
  - `start` pulsed while busy → ignored.
  - `reset` asserted in WALL_WAIT → IDLE on the next cycle, all outputs 0, no `done`.
